// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcode values, immediate extension modes and
// default datapath widths used by the ID-stage immediate logic.
package dlx_pkg;

  localparam int OUT_W_DEF = 32;
  localparam int OP_W_DEF  = 6;

  typedef enum logic [2:0] {
    EXT_NONE = 3'd0,
    EXT_S16  = 3'd1,
    EXT_Z16  = 3'd2,
    EXT_HI16 = 3'd3,
    EXT_S26  = 3'd4
  } ext_mode_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SGTI  = 6'h1B;
  localparam logic [5:0] OP_SLEI  = 6'h1C;
  localparam logic [5:0] OP_SGEI  = 6'h1D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/imm_ext_stage_if.sv
// ID->EX immediate slot bus: decode-side input handshake, flush, and the
// EX-side output handshake with the decoded immediate fields.
interface imm_ext_stage_if #(
  parameter int OUT_W = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [2:0]       out_mode;
  logic             out_is_imm;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_mode, out_is_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_imm, out_mode, out_is_imm, out_illegal
  );
endinterface

// File: rtl/imm_ext_decode.sv
// Combinational opcode classifier and immediate extension mux; its results are
// stored by the skid so replayed entries are never re-decoded.
module imm_ext_decode
  import dlx_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic [31:0]      instr,
  output logic [OUT_W-1:0] imm,
  output ext_mode_t        mode,
  output logic             is_imm,
  output logic             illegal
);

  logic [OP_W-1:0] opcode;
  assign opcode = instr[31 -: OP_W];

  always_comb begin
    mode    = EXT_NONE;
    is_imm  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: ;
      OP_J, OP_JAL: begin
        mode   = EXT_S26;
        is_imm = 1'b1;
      end
      OP_BEQZ, OP_BNEZ, OP_ADDI, OP_SUBI,
      OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
        mode   = EXT_S16;
        is_imm = 1'b1;
      end
      OP_ADDUI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        mode   = EXT_Z16;
        is_imm = 1'b1;
      end
      OP_LHI: begin
        mode   = EXT_HI16;
        is_imm = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Signed casts give zero-width-safe sign fill even when OUT_W == 26.
  always_comb begin
    imm = '0;
    case (mode)
      EXT_S16:  imm = OUT_W'($signed(instr[15:0]));
      EXT_Z16:  imm = OUT_W'(instr[15:0]);
      EXT_HI16: imm = {instr[15:0], {(OUT_W-16){1'b0}}};
      EXT_S26:  imm = OUT_W'($signed(instr[25:0]));
      default:  imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Decode-stage immediate controller: decodes on entry, then holds results in a
// 2-entry shift skid (entry 0 drives EX) with synchronous flush.
module imm_ext_stage
  import dlx_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input logic            clk,
  input logic            rst_n,
  imm_ext_stage_if.slave bus
);

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    ext_mode_t        mode;
    logic             is_imm;
    logic             illegal;
  } entry_t;

  entry_t dec;
  entry_t head;
  entry_t tail;
  logic   head_valid;
  logic   tail_valid;
  logic   accept;
  logic   drain;

  imm_ext_decode #(
    .OUT_W (OUT_W),
    .OP_W  (OP_W)
  ) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec.imm),
    .mode    (dec.mode),
    .is_imm  (dec.is_imm),
    .illegal (dec.illegal)
  );

  // in_ready is taken straight from the tail flop, so it never sees out_ready.
  assign accept = bus.in_valid & ~tail_valid;
  assign drain  = head_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head       <= '0;
      tail       <= '0;
    end else if (bus.flush) begin
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else if (drain) begin
      if (tail_valid) begin
        head       <= tail;
        tail_valid <= 1'b0;
      end else if (accept) begin
        head <= dec;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (head_valid) begin
        tail       <= dec;
        tail_valid <= 1'b1;
      end else begin
        head       <= dec;
        head_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = ~tail_valid;
  assign bus.out_valid   = head_valid;
  assign bus.out_imm     = head.imm;
  assign bus.out_mode    = head.mode;
  assign bus.out_is_imm  = head.is_imm;
  assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: decode table, skid ordering, flush and
// asynchronous reset behaviour against hand-computed values.
module tb_imm_ext_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  imm_ext_stage_if #(.OUT_W(32)) bus ();

  imm_ext_stage #(
    .OUT_W (32),
    .OP_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk16(input logic [5:0] op, input logic [15:0] imm16);
    return {op, 10'h000, imm16};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm got=%h exp=0", bus.out_imm); end
    checks++; if (bus.out_mode !== 3'd0) begin errors++; $display("FAIL reset_out_mode got=%0d exp=0", bus.out_mode); end
    checks++; if (bus.out_is_imm !== 1'b0) begin errors++; $display("FAIL reset_out_is_imm got=%0b exp=0", bus.out_is_imm); end
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal got=%0b exp=0", bus.out_illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] instr_v [8];
    logic [31:0] imm_v   [8];
    logic [2:0]  mode_v  [8];
    logic        isi_v   [8];
    logic        ill_v   [8];
    instr_v[0] = mk16(6'h08, 16'hFFF0);      imm_v[0] = 32'hFFFF_FFF0; mode_v[0] = 3'd1; isi_v[0] = 1; ill_v[0] = 0;
    instr_v[1] = mk16(6'h0C, 16'h8001);      imm_v[1] = 32'h0000_8001; mode_v[1] = 3'd2; isi_v[1] = 1; ill_v[1] = 0;
    instr_v[2] = mk16(6'h0F, 16'h1234);      imm_v[2] = 32'h1234_0000; mode_v[2] = 3'd3; isi_v[2] = 1; ill_v[2] = 0;
    instr_v[3] = {6'h02, 26'h200_0000};      imm_v[3] = 32'hFE00_0000; mode_v[3] = 3'd4; isi_v[3] = 1; ill_v[3] = 0;
    instr_v[4] = mk16(6'h3F, 16'hABCD);      imm_v[4] = 32'h0000_0000; mode_v[4] = 3'd0; isi_v[4] = 0; ill_v[4] = 1;
    instr_v[5] = mk16(6'h00, 16'hFFFF);      imm_v[5] = 32'h0000_0000; mode_v[5] = 3'd0; isi_v[5] = 0; ill_v[5] = 0;
    instr_v[6] = mk16(6'h23, 16'h7FFF);      imm_v[6] = 32'h0000_7FFF; mode_v[6] = 3'd1; isi_v[6] = 1; ill_v[6] = 0;
    instr_v[7] = mk16(6'h17, 16'hFFFF);      imm_v[7] = 32'h0000_FFFF; mode_v[7] = 3'd2; isi_v[7] = 1; ill_v[7] = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = instr_v[i];
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL decode%0d_valid got=%0b exp=1", i, bus.out_valid); end
      checks++; if (bus.out_imm !== imm_v[i]) begin errors++; $display("FAIL decode%0d_imm got=%h exp=%h", i, bus.out_imm, imm_v[i]); end
      checks++; if (bus.out_mode !== mode_v[i]) begin errors++; $display("FAIL decode%0d_mode got=%0d exp=%0d", i, bus.out_mode, mode_v[i]); end
      checks++; if (bus.out_is_imm !== isi_v[i]) begin errors++; $display("FAIL decode%0d_is_imm got=%0b exp=%0b", i, bus.out_is_imm, isi_v[i]); end
      checks++; if (bus.out_illegal !== ill_v[i]) begin errors++; $display("FAIL decode%0d_illegal got=%0b exp=%0b", i, bus.out_illegal, ill_v[i]); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_skid();
    logic [31:0] seen [3];
    int          got;
    logic        xo;
    logic        xi;
    logic [31:0] v;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk16(6'h08, 16'd1);
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_after1 got=%0b exp=1", bus.in_ready); end
    checks++; if (bus.out_imm !== 32'd1) begin errors++; $display("FAIL skid_head_after1 got=%h exp=1", bus.out_imm); end
    bus.in_instr = mk16(6'h08, 16'd2);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_after2 got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_imm !== 32'd1) begin errors++; $display("FAIL skid_head_after2 got=%h exp=1", bus.out_imm); end
    bus.in_instr = mk16(6'h08, 16'd3);
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_full got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'd1) begin errors++; $display("FAIL skid_hold got=%0b/%h exp=1/1", bus.out_valid, bus.out_imm); end
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      xo = bus.out_valid & bus.out_ready;
      xi = bus.in_valid & bus.in_ready;
      v  = bus.out_imm;
      tick();
      if (xo) begin
        seen[got] = v;
        got++;
      end
      if (xi) bus.in_valid = 1'b0;
      if (c == 0) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_slot_freed got=%0b exp=1", bus.in_ready); end
      end
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL skid_count got=%0d exp=3", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (seen[i] !== 32'(i + 1)) begin errors++; $display("FAIL skid_order%0d got=%h exp=%h", i, seen[i], 32'(i + 1)); end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got=%0b exp=0", bus.out_valid); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic leaked;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk16(6'h08, 16'd4);
    tick();
    bus.in_instr  = mk16(6'h08, 16'd5);
    tick();
    bus.in_instr  = mk16(6'h08, 16'd6);
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got=%0b exp=1", bus.in_ready); end
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk16(6'h08, 16'd7);
    tick();
    bus.in_instr  = mk16(6'h08, 16'd8);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_one_ready got=%0b exp=1", bus.in_ready); end
    leaked = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.out_valid === 1'b1) leaked = 1'b1;
    end
    checks++; if (leaked !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%0b exp=0", leaked); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk16(6'h08, 16'd9);
    tick();
    bus.in_instr  = mk16(6'h08, 16'd10);
    tick();
    bus.in_valid  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk16(6'h08, 16'd11);
    tick();
    bus.in_valid  = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'd11) begin errors++; $display("FAIL rstmid_first got=%0b/%h exp=1/0000000b", bus.out_valid, bus.out_imm); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%0b exp=0", bus.out_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_decode();
    test_skid();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
